// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory dump path.
package mem_dump_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        EMIT,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] word;
    } mem_record_t;

endpackage

// File: rtl/word_assembler.sv
// Collects byte reads into a little-endian 32-bit word, one lane per load.
module word_assembler
    import mem_dump_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              load,
    input  logic [LANE_W-1:0] lane,
    input  logic [7:0]        byte_in,
    output logic [31:0]       word
);

    always_ff @(posedge clk) begin
        if (clear) begin
            word <= '0;
        end else if (load) begin
            word[8*lane +: 8] <= byte_in;
        end
    end

endmodule

// File: rtl/mem_dumper.sv
// Reads num_words little-endian words from a byte memory starting at base_addr
// and streams them out as (address, word) records over valid/ready.
module mem_dumper
    import mem_dump_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_word
);

    state_t              state, state_nxt;
    logic [LANE_W-1:0]   k, k_nxt;
    logic [CNT_W-1:0]    i, i_nxt;
    logic [CNT_W-1:0]    num_q, num_nxt;
    logic [ADDR_W-1:0]   word_addr, word_addr_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt, out_addr_nxt;
    logic                mem_rd_nxt, busy_nxt, done_nxt, out_valid_nxt;
    logic                asm_clear;
    logic                rd_d1;
    logic [LANE_W-1:0]   lane_d1;

    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        i_nxt         = i;
        num_nxt       = num_q;
        word_addr_nxt = word_addr;
        mem_rd_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        out_valid_nxt = 1'b0;
        out_addr_nxt  = out_addr;
        asm_clear     = 1'b0;

        unique case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    num_nxt       = num_words;
                    word_addr_nxt = base_addr;
                    i_nxt         = '0;
                    k_nxt         = '0;
                    busy_nxt      = 1'b1;
                    asm_clear     = 1'b1;
                    if (num_words == '0) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt    = READ;
                        mem_rd_nxt   = 1'b1;
                        mem_addr_nxt = base_addr;
                    end
                end
            end
            READ: begin
                if (k == LANE_W'(BYTES_PER_WORD - 1)) begin
                    state_nxt = CAPT;
                    k_nxt     = '0;
                end else begin
                    k_nxt        = k + 1'b1;
                    mem_rd_nxt   = 1'b1;
                    mem_addr_nxt = word_addr + ADDR_W'(k) + ADDR_W'(1);
                end
            end
            CAPT: begin
                state_nxt     = EMIT;
                out_valid_nxt = 1'b1;
                out_addr_nxt  = word_addr;
            end
            EMIT: begin
                out_valid_nxt = 1'b1;
                if (out_valid && out_ready) begin
                    out_valid_nxt = 1'b0;
                    i_nxt         = i + CNT_W'(1);
                    if (i_nxt == num_q) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        // The next word's first read is issued on the handshake edge itself
                        state_nxt     = READ;
                        word_addr_nxt = word_addr + ADDR_W'(BYTES_PER_WORD);
                        mem_rd_nxt    = 1'b1;
                        mem_addr_nxt  = word_addr + ADDR_W'(BYTES_PER_WORD);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            i         <= '0;
            num_q     <= '0;
            word_addr <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            rd_d1     <= 1'b0;
            lane_d1   <= '0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            i         <= i_nxt;
            num_q     <= num_nxt;
            word_addr <= word_addr_nxt;
            mem_rd    <= mem_rd_nxt;
            mem_addr  <= mem_addr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            out_valid <= out_valid_nxt;
            out_addr  <= out_addr_nxt;
            rd_d1     <= mem_rd;
            lane_d1   <= k;
        end
    end

    // rd_d1/lane_d1 tag the byte on mem_rdata this cycle with the read that produced it
    word_assembler u_word_assembler (
        .clk     (clk),
        .clear   (rst | asm_clear),
        .load    (rd_d1),
        .lane    (lane_d1),
        .byte_in (mem_rdata),
        .word    (out_word)
    );

endmodule

// File: tb/tb_mem_dumper.sv
// Randomized self-checking bench for mem_dumper against a record-level model.
module tb_mem_dumper;
    import mem_dump_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic        busy, done, mem_rd;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_addr, out_word;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [logic [31:0]];

    mem_dumper #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_word  (out_word)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    // Memory returns data one cycle after the read; garbage otherwise
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= byte_at(mem_addr);
        else        mem_rdata <= 8'($urandom);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_mem_rd"},    mem_rd, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_mem_addr"},  mem_addr, 0);
        check({tag, "_out_addr"},  out_addr, 0);
        check({tag, "_out_word"},  out_word, 0);
    endtask

    // mode: 0 always ready, 1 random ready, 2 stall first record 10 cycles
    task automatic run_dump(input logic [31:0] base, input int n, input int mode,
                            input int glitch_at, input int abort_at);
        mem_record_t exp_recs[$];
        mem_record_t got_recs[$];
        logic [31:0] exp_reads[$];
        logic [31:0] got_reads[$];
        mem_record_t r;
        int c = 0, first_valid = -1, done_cycle = -1, done_cnt = 0, last_hs = -1, stall = 0;
        bit finished = 0;

        for (int w = 0; w < n; w++) begin
            r.addr = base + 32'(4 * w);
            r.word = {byte_at(r.addr + 32'd3), byte_at(r.addr + 32'd2),
                      byte_at(r.addr + 32'd1), byte_at(r.addr)};
            exp_recs.push_back(r);
            for (int b = 0; b < 4; b++) exp_reads.push_back(r.addr + 32'(b));
        end

        base_addr = base;
        num_words = 16'(n);
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_cycle0", busy, 1);

        while (c < 3000) begin
            if (abort_at >= 0 && c == abort_at + 1) begin
                check_idle_outputs("after_rst");
                rst = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("abort_no_done", done, 0);
                    check("abort_no_rd", mem_rd, 0);
                end
                return;
            end

            case (mode)
                1:       out_ready = ($urandom_range(0, 3) != 0);
                2:       out_ready = !(out_valid && got_recs.size() == 0 && stall < 10);
                default: out_ready = 1'b1;
            endcase
            if (mode == 2 && out_valid && !out_ready) begin
                stall++;
                check("stall_no_rd", mem_rd, 0);
            end
            if (c == glitch_at) begin
                start     = 1'b1;
                base_addr = base ^ 32'h0000_0100;
                num_words = 16'(n + 3);
            end else begin
                start = 1'b0;
            end
            if (c == abort_at) rst = 1'b1;

            if (mem_rd) got_reads.push_back(mem_addr);
            if (out_valid) begin
                if (first_valid < 0) first_valid = c;
                if (got_recs.size() < exp_recs.size()) begin
                    check("rec_addr_live", out_addr, exp_recs[got_recs.size()].addr);
                    check("rec_word_live", out_word, exp_recs[got_recs.size()].word);
                end
                if (out_ready) begin
                    r.addr = out_addr;
                    r.word = out_word;
                    got_recs.push_back(r);
                    last_hs = c + 1;
                end
            end
            if (done) begin
                done_cnt++;
                done_cycle = c;
            end
            if (done_cycle >= 0 && c == done_cycle + 1) begin
                check("busy_fall", busy, 0);
                finished = 1;
                break;
            end
            @(negedge clk);
            c++;
        end

        check("dump_finished", finished, 1);
        check("n_recs", got_recs.size(), n);
        for (int j = 0; j < got_recs.size() && j < n; j++) begin
            check("rec_addr", got_recs[j].addr, exp_recs[j].addr);
            check("rec_word", got_recs[j].word, exp_recs[j].word);
        end
        check("n_reads", got_reads.size(), 4 * n);
        for (int j = 0; j < got_reads.size() && j < 4 * n; j++)
            check("read_addr", got_reads[j], exp_reads[j]);
        check("done_count", done_cnt, 1);
        if (n == 0) begin
            check("zero_done_cycle", done_cycle, 0);
            check("zero_no_valid", first_valid, -1);
        end else begin
            check("done_after_last_hs", done_cycle, last_hs);
            if (mode == 0) begin
                check("first_valid_cycle", first_valid, 5);
                check("throughput", last_hs, 6 * n);
            end
        end
        if (base == 32'h0 && got_recs.size() > 0)
            check("basic_word0", got_recs[0].word, 32'h0050_0513);
    endtask

    initial begin
        logic [7:0] seed_bytes [4];
        seed_bytes[0] = 8'h13; seed_bytes[1] = 8'h05; seed_bytes[2] = 8'h50; seed_bytes[3] = 8'h00;
        for (int a = 0; a < 4; a++) mem[32'(a)] = seed_bytes[a];
        for (int a = 4; a < 16; a++) mem[32'(a)] = 8'($urandom);

        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_dump(32'h0000_0000, 4, 0, -1, -1);   // basic
        run_dump(32'h0000_0100, 3, 2, -1, -1);   // back-pressure
        run_dump(32'h0000_0080, 0, 0, -1, -1);   // zero length
        run_dump(32'hFFFF_FFFC, 2, 0, -1, -1);   // wrap-around
        run_dump(32'h0000_0040, 3, 0, -1, 7);    // reset during word 1 reads
        run_dump(32'h0000_0040, 3, 0, -1, -1);
        run_dump(32'h0000_0200, 3, 0, 8, -1);    // start while busy
        for (int t = 0; t < 6; t++)
            run_dump($urandom, $urandom_range(1, 5), 1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
